music_player_ctrl: RTL and testbench

Keyboard-command decoder and playback state holder for the audio player. It accepts one ASCII scan code per rising edge of `kybrd_data_ready` and maintains the following state:
- play/pause state
- direction
- track select
- playback speed

It issues single-cycle restart pulses. It sits between the PS/2 keyboard front end and the flash address generator / sample-rate divider, and generalises the fixed five-key controller with a configurable track count, speed range and key map, plus edge-qualified command acceptance.

---
 rtl/music_player_ctrl.sv | 118 +++++++++++
 tb/tb_music_player_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/music_player_ctrl.sv
// Keyboard command decoder: play/pause, direction, track and speed state plus restart/ack/err pulses.
// One register stage from the accepting clk edge to every output; one command per rising strobe.
module music_player_ctrl #(
    parameter int                 KEY_W         = 8,
    parameter int                 NUM_TRACKS    = 4,
    parameter int                 SPEED_W       = 3,
    parameter int                 SPEED_DEFAULT = 3,
    parameter logic [KEY_W-1:0]   KEY_PLAY      = 8'h45,
    parameter logic [KEY_W-1:0]   KEY_PAUSE     = 8'h44,
    parameter logic [KEY_W-1:0]   KEY_FWD       = 8'h46,
    parameter logic [KEY_W-1:0]   KEY_BWD       = 8'h42,
    parameter logic [KEY_W-1:0]   KEY_RESTART   = 8'h52,
    parameter logic [KEY_W-1:0]   KEY_NEXT      = 8'h4E,
    parameter logic [KEY_W-1:0]   KEY_PREV      = 8'h50,
    parameter logic [KEY_W-1:0]   KEY_FASTER    = 8'h55,
    parameter logic [KEY_W-1:0]   KEY_SLOWER    = 8'h4C,
    localparam int                TRACK_W       = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [KEY_W-1:0]      keyboard_input,
    input  logic                  kybrd_data_ready,
    output logic                  forward,
    output logic                  pause,
    output logic                  restart,
    output logic [TRACK_W-1:0]    track_sel,
    output logic [SPEED_W-1:0]    speed,
    output logic                  cmd_ack,
    output logic                  cmd_err
);

    typedef enum logic {
        ST_PAUSED  = 1'b0,
        ST_PLAYING = 1'b1
    } state_t;

    localparam logic [SPEED_W-1:0] SPEED_RST = SPEED_W'(SPEED_DEFAULT);
    localparam logic [SPEED_W-1:0] SPEED_MAX = {SPEED_W{1'b1}};
    localparam logic [SPEED_W-1:0] SPEED_ONE = SPEED_W'(1);
    localparam logic [TRACK_W-1:0] TRACK_ONE = TRACK_W'(1);

    state_t               r_state;
    logic                 r_forward;
    logic                 r_restart;
    logic [TRACK_W-1:0]   r_track_sel;
    logic [SPEED_W-1:0]   r_speed;
    logic                 r_cmd_ack;
    logic                 r_cmd_err;
    logic                 r_dr_q;

    logic                 w_accept;
    logic                 w_speed_at_max;
    logic                 w_speed_at_min;

    // r_dr_q resets high so a strobe held across reset release is not a new command.
    assign w_accept       = kybrd_data_ready & ~r_dr_q;
    assign w_speed_at_max = (r_speed == SPEED_MAX);
    assign w_speed_at_min = (r_speed == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_PAUSED;
            r_forward   <= 1'b1;
            r_restart   <= 1'b0;
            r_track_sel <= '0;
            r_speed     <= SPEED_RST;
            r_cmd_ack   <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_dr_q      <= 1'b1;
        end else begin
            r_dr_q    <= kybrd_data_ready;
            r_restart <= 1'b0;
            r_cmd_ack <= 1'b0;
            r_cmd_err <= 1'b0;
            if (w_accept) begin
                r_cmd_ack <= 1'b1;
                // Priority chain: first matching key parameter wins.
                if (keyboard_input == KEY_PLAY) begin
                    r_state <= ST_PLAYING;
                end else if (keyboard_input == KEY_PAUSE) begin
                    r_state <= ST_PAUSED;
                end else if (keyboard_input == KEY_FWD) begin
                    r_forward <= 1'b1;
                end else if (keyboard_input == KEY_BWD) begin
                    r_forward <= 1'b0;
                end else if (keyboard_input == KEY_RESTART) begin
                    r_restart <= 1'b1;
                end else if (keyboard_input == KEY_NEXT) begin
                    r_track_sel <= r_track_sel + TRACK_ONE;
                    r_restart   <= 1'b1;
                end else if (keyboard_input == KEY_PREV) begin
                    r_track_sel <= r_track_sel - TRACK_ONE;
                    r_restart   <= 1'b1;
                end else if (keyboard_input == KEY_FASTER) begin
                    if (!w_speed_at_max) begin
                        r_speed <= r_speed + SPEED_ONE;
                    end
                end else if (keyboard_input == KEY_SLOWER) begin
                    if (!w_speed_at_min) begin
                        r_speed <= r_speed - SPEED_ONE;
                    end
                end else begin
                    r_cmd_ack <= 1'b0;
                    r_cmd_err <= 1'b1;
                end
            end
        end
    end

    assign pause     = (r_state == ST_PAUSED);
    assign forward   = r_forward;
    assign restart   = r_restart;
    assign track_sel = r_track_sel;
    assign speed     = r_speed;
    assign cmd_ack   = r_cmd_ack;
    assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_music_player_ctrl.sv
// Bench for music_player_ctrl: directed vector table, a hand sequence, then random traffic vs a reference model.
module tb_music_player_ctrl;

    localparam int NT = 4;
    localparam int SW = 3;
    localparam int SD = 3;

    logic       clk;
    logic       reset;
    logic [7:0] keyboard_input;
    logic       kybrd_data_ready;
    logic       forward;
    logic       pause;
    logic       restart;
    logic [1:0] track_sel;
    logic [2:0] speed;
    logic       cmd_ack;
    logic       cmd_err;

    music_player_ctrl #(
        .KEY_W(8), .NUM_TRACKS(NT), .SPEED_W(SW), .SPEED_DEFAULT(SD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .keyboard_input(keyboard_input),
        .kybrd_data_ready(kybrd_data_ready),
        .forward(forward),
        .pause(pause),
        .restart(restart),
        .track_sel(track_sel),
        .speed(speed),
        .cmd_ack(cmd_ack),
        .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         dr;
        logic [7:0] key;
        int         p, f, r, a, e, t, s;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state, updated once per clock edge from the applied inputs.
    int m_pause, m_fwd, m_restart, m_ack, m_err, m_track, m_speed, m_drq;

    function automatic void add(bit rst, bit dr, logic [7:0] key,
                                int p, int f, int r, int a, int e, int t, int s);
        vec_t v;
        v.rst = rst; v.dr = dr; v.key = key;
        v.p = p; v.f = f; v.r = r; v.a = a; v.e = e; v.t = t; v.s = s;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(bit rst, bit dr, logic [7:0] k);
        m_restart = 0; m_ack = 0; m_err = 0;
        if (rst) begin
            m_pause = 1; m_fwd = 1; m_track = 0; m_speed = SD; m_drq = 1;
        end else begin
            if (dr && m_drq == 0) begin
                m_ack = 1;
                case (k)
                    8'h45: m_pause = 0;
                    8'h44: m_pause = 1;
                    8'h46: m_fwd = 1;
                    8'h42: m_fwd = 0;
                    8'h52: m_restart = 1;
                    8'h4E: begin m_track = (m_track + 1) % NT;      m_restart = 1; end
                    8'h50: begin m_track = (m_track + NT - 1) % NT; m_restart = 1; end
                    8'h55: m_speed = (m_speed < (1 << SW) - 1) ? m_speed + 1 : m_speed;
                    8'h4C: m_speed = (m_speed > 0) ? m_speed - 1 : 0;
                    default: begin m_ack = 0; m_err = 1; end
                endcase
            end
            m_drq = dr ? 1 : 0;
        end
    endtask

    task automatic drive(bit r, bit d, logic [7:0] k);
        reset = r; kybrd_data_ready = d; keyboard_input = k;
        @(posedge clk);
        model_edge(r, d, k);
        #1;
    endtask

    task automatic chk_all(string tag, int p, int f, int r, int a, int e, int t, int s);
        chk({tag, ".pause"},     int'(pause),     p);
        chk({tag, ".forward"},   int'(forward),   f);
        chk({tag, ".restart"},   int'(restart),   r);
        chk({tag, ".cmd_ack"},   int'(cmd_ack),   a);
        chk({tag, ".cmd_err"},   int'(cmd_err),   e);
        chk({tag, ".track_sel"}, int'(track_sel), t);
        chk({tag, ".speed"},     int'(speed),     s);
    endtask

    logic [7:0] keys [9];

    initial begin
        keys = '{8'h45, 8'h44, 8'h46, 8'h42, 8'h52, 8'h4E, 8'h50, 8'h55, 8'h4C};
        reset = 1'b1; kybrd_data_ready = 1'b0; keyboard_input = 8'h00;

        //  rst dr key     p  f  r  a  e  t  s
        add(1, 0, 8'h00,   1, 1, 0, 0, 0, 0, 3);
        add(0, 0, 8'h00,   1, 1, 0, 0, 0, 0, 3);
        add(0, 1, 8'h45,   0, 1, 0, 1, 0, 0, 3);
        add(0, 1, 8'h44,   0, 1, 0, 0, 0, 0, 3);
        add(0, 1, 8'h46,   0, 1, 0, 0, 0, 0, 3);
        add(0, 1, 8'h42,   0, 1, 0, 0, 0, 0, 3);
        add(0, 1, 8'h42,   0, 1, 0, 0, 0, 0, 3);
        add(0, 0, 8'h42,   0, 1, 0, 0, 0, 0, 3);
        add(0, 1, 8'h52,   0, 1, 1, 1, 0, 0, 3);
        for (int i = 0; i < 3; i++) add(0, 1, 8'h52, 0, 1, 0, 0, 0, 0, 3);
        for (int i = 0; i < 4; i++) add(0, 0, 8'h52, 0, 1, 0, 0, 0, 0, 3);
        add(0, 1, 8'h52,   0, 1, 1, 1, 0, 0, 3);
        add(0, 0, 8'h52,   0, 1, 0, 0, 0, 0, 3);
        for (int i = 1; i <= 4; i++) begin
            add(0, 1, 8'h4E, 0, 1, 1, 1, 0, i % NT, 3);
            add(0, 0, 8'h4E, 0, 1, 0, 0, 0, i % NT, 3);
        end
        add(0, 1, 8'h50,   0, 1, 1, 1, 0, 3, 3);
        add(0, 0, 8'h50,   0, 1, 0, 0, 0, 3, 3);
        add(1, 0, 8'h00,   1, 1, 0, 0, 0, 0, 3);
        add(0, 0, 8'h00,   1, 1, 0, 0, 0, 0, 3);
        for (int i = 0; i < 6; i++) begin
            add(0, 1, 8'h55, 1, 1, 0, 1, 0, 0, (4 + i > 7) ? 7 : 4 + i);
            add(0, 0, 8'h55, 1, 1, 0, 0, 0, 0, (4 + i > 7) ? 7 : 4 + i);
        end
        for (int i = 0; i < 8; i++) begin
            add(0, 1, 8'h4C, 1, 1, 0, 1, 0, 0, (6 - i < 0) ? 0 : 6 - i);
            add(0, 0, 8'h4C, 1, 1, 0, 0, 0, 0, (6 - i < 0) ? 0 : 6 - i);
        end
        add(0, 1, 8'h41,   1, 1, 0, 0, 1, 0, 0);
        add(0, 0, 8'h41,   1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 8'h42,   1, 0, 0, 1, 0, 0, 0);
        add(0, 0, 8'h42,   1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h45,   0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 8'h45,   0, 0, 0, 0, 0, 0, 0);
        // Reset at the same edge as a BWD strobe, then the strobe stays high through release.
        add(1, 1, 8'h42,   1, 1, 0, 0, 0, 0, 3);
        add(0, 1, 8'h42,   1, 1, 0, 0, 0, 0, 3);
        add(0, 1, 8'h42,   1, 1, 0, 0, 0, 0, 3);
        add(0, 0, 8'h42,   1, 1, 0, 0, 0, 0, 3);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].dr, vecs[i].key);
            chk_all($sformatf("vec%0d", i), vecs[i].p, vecs[i].f, vecs[i].r,
                    vecs[i].a, vecs[i].e, vecs[i].t, vecs[i].s);
        end

        // Reset mid-pulse: a NEXT pulse is cut and its track step undone by reset.
        drive(0, 1, 8'h4E);
        chk_all("hand_next", 1, 1, 1, 1, 0, 1, 3);
        drive(1, 1, 8'h4E);
        chk_all("hand_rst_mid", 1, 1, 0, 0, 0, 0, 3);
        drive(0, 0, 8'h00);
        drive(0, 1, 8'h50);
        chk_all("hand_prev_wrap", 1, 1, 1, 1, 0, 3, 3);
        drive(0, 1, 8'h4E);
        chk_all("hand_hold", 1, 1, 0, 0, 0, 3, 3);

        drive(1, 0, 8'h00);
        for (int c = 0; c < 3000; c++) begin
            bit         r, d;
            logic [7:0] k;
            r = ($urandom_range(0, 63) == 0);
            d = $urandom_range(0, 1) == 1;
            k = ($urandom_range(0, 9) == 9) ? 8'($urandom) : keys[$urandom_range(0, 8)];
            drive(r, d, k);
            chk_all($sformatf("rnd%0d", c), m_pause, m_fwd, m_restart, m_ack, m_err, m_track, m_speed);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
